// File: rtl/vpu_issue_queue.sv
`default_nettype none
// ============================================================================
// vpu_issue_queue : decode-to-VPU instruction FIFO with outstanding-op cap
//                   and HALT drain tracking.
// Revision        : 1.0
// ============================================================================
module vpu_issue_queue #(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               VPU_start,
    input  logic               issue_en,
    input  logic [INSTR_W-1:0] instr,
    input  logic               halt,
    output logic               VPU_rdy,
    output logic               vpu_valid,
    output logic [INSTR_W-1:0] vpu_instr,
    input  logic               vpu_ready,
    input  logic               vpu_done,
    output logic               vpu_idle,
    output logic               drained,
    output logic               err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_OW = $clog2(MAX_OUT + 1);

    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);
    localparam logic [c_OW-1:0] c_MAX_OUT = c_OW'(MAX_OUT);
    localparam logic [c_AW-1:0] c_PTR_ONE = 1;
    localparam logic [c_AW:0]   c_CNT_ONE = 1;
    localparam logic [c_OW-1:0] c_OUT_ONE = 1;

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_DRAIN  = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [c_AW:0]      count_q, count_d;
    logic [c_AW-1:0]    head_q,  head_d;
    logic [c_AW-1:0]    tail_q,  tail_d;
    logic [c_OW-1:0]    out_q,   out_d;
    logic               err_q,   err_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];

    logic w_enq;
    logic w_deq;

    // Handshake outputs come only from registers so the CPU stall path stays short.
    assign VPU_rdy   = (state_q == c_RUN) & (count_q != c_FULL);
    assign vpu_valid = (count_q != '0) & (out_q < c_MAX_OUT);
    assign vpu_instr = mem_q[head_q];
    assign vpu_idle  = (count_q == '0) & (out_q == '0);
    assign drained   = (state_q == c_HALTED);
    assign err       = err_q;

    // A HALT in the same slot as a VPU instruction wins, so that word is dropped.
    assign w_enq = VPU_start & issue_en & VPU_rdy & ~halt;
    assign w_deq = vpu_valid & vpu_ready;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        out_d   = out_q;
        err_d   = err_q;
        state_d = state_q;

        if (w_enq) begin
            mem_d[tail_q] = instr;
            tail_d        = tail_q + c_PTR_ONE;
        end
        if (w_deq) begin
            head_d = head_q + c_PTR_ONE;
        end

        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: ;
        endcase

        if (w_deq && !vpu_done) begin
            out_d = out_q + c_OUT_ONE;
        end else if (!w_deq && vpu_done) begin
            if (out_q == '0) begin
                err_d = 1'b1;
            end else begin
                out_d = out_q - c_OUT_ONE;
            end
        end

        if (halt && VPU_start) begin
            err_d = 1'b1;
        end

        case (state_q)
            c_RUN:   if (halt && issue_en) state_d = c_DRAIN;
            c_DRAIN: if (vpu_idle)         state_d = c_HALTED;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_RUN;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire
